// File: rtl/guess_hint_ctrl.sv
// Secret-code guessing controller: latches a W-bit secret, takes up to MAX_TRIES guesses,
// shows a per-bit XNOR hint and reports WIN/LOSE. Optional popcount output: HINT_COUNT_EN.
module guess_hint_ctrl #(
  parameter int W         = 6,
  parameter int MAX_TRIES = 8,
  localparam int TW       = $clog2(MAX_TRIES + 1),
  localparam int CW       = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          enter,
  input  logic [W-1:0]  sw_senha,
  input  logic [W-1:0]  sw_tentativa,
  output logic [W-1:0]  hint,
  output logic [TW-1:0] tries_left,
  output logic          playing,
  output logic          win,
`ifdef HINT_COUNT_EN
  output logic          lose,
  output logic [CW-1:0] match_cnt
`else
  output logic          lose
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting for the first start rise
  // PLAY  | round active, guesses accepted
  // WIN   | last accepted guess equalled the secret, outputs frozen
  // LOSE  | tries exhausted without a match, outputs frozen
  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  secret, secret_nx, hint_nx;
  logic [TW-1:0] tries_nx;
  logic          start_d, enter_d;
  logic          start_rise, enter_rise;

  assign start_rise = start & ~start_d;
  assign enter_rise = enter & ~enter_d;

  always_comb begin
    state_nx  = state;
    secret_nx = secret;
    hint_nx   = hint;
    tries_nx  = tries_left;
    // start takes priority over a same-cycle guess in every state
    if (start_rise) begin
      state_nx  = PLAY;
      secret_nx = sw_senha;
      hint_nx   = '0;
      tries_nx  = TW'(MAX_TRIES);
    end else begin
      case (state)
        PLAY: begin
          if (enter_rise) begin
            hint_nx  = ~(secret ^ sw_tentativa);
            tries_nx = tries_left - 1'b1;
            if (sw_tentativa == secret)
              state_nx = WIN;
            else if (tries_left == TW'(1))
              state_nx = LOSE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // edge-detect history tracks the inputs even in reset, so a held key gives no edge
    start_d <= start;
    enter_d <= enter;
    if (rst) begin
      state      <= IDLE;
      secret     <= '0;
      hint       <= '0;
      tries_left <= '0;
    end else begin
      state      <= state_nx;
      secret     <= secret_nx;
      hint       <= hint_nx;
      tries_left <= tries_nx;
    end
  end

  assign playing = (state == PLAY);
  assign win     = (state == WIN);
  assign lose    = (state == LOSE);

`ifdef HINT_COUNT_EN
  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++)
      c = c + CW'(v[i]);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      match_cnt <= '0;
    else
      match_cnt <= popcount(hint_nx);
  end
`endif

endmodule

// File: tb/tb_guess_hint_ctrl.sv
// Table-driven self-checking bench for guess_hint_ctrl (W=6, MAX_TRIES=3) with a
// scoreboard queue of expected outputs; checks match_cnt when HINT_COUNT_EN is defined.
module tb_guess_hint_ctrl;
  localparam int W  = 6;
  localparam int MT = 3;
  localparam int TW = 2;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst, start, enter;
  logic [W-1:0]  sw_senha, sw_tentativa, hint_o;
  logic [TW-1:0] tries_left;
  logic          playing, win, lose;
`ifdef HINT_COUNT_EN
  logic [CW-1:0] match_cnt;
`endif

  always #5 clk = ~clk;

  guess_hint_ctrl #(.W(W), .MAX_TRIES(MT)) dut (
    .clk(clk), .rst(rst), .start(start), .enter(enter),
    .sw_senha(sw_senha), .sw_tentativa(sw_tentativa),
    .hint(hint_o), .tries_left(tries_left),
    .playing(playing), .win(win),
`ifdef HINT_COUNT_EN
    .lose(lose), .match_cnt(match_cnt)
`else
    .lose(lose)
`endif
  );

  typedef struct packed {
    logic          rst;
    logic          start;
    logic          enter;
    logic [W-1:0]  senha;
    logic [W-1:0]  tent;
    logic [W-1:0]  e_hint;
    logic [TW-1:0] e_tries;
    logic [2:0]    e_flags;  // {playing, win, lose}
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  function automatic vec_t mk(input logic r, s, e, input logic [W-1:0] sn, tn, eh,
                              input logic [TW-1:0] et, input logic [2:0] ef,
                              input logic [CW-1:0] ec);
    vec_t v;
    v = '{rst:r, start:s, enter:e, senha:sn, tent:tn, e_hint:eh, e_tries:et,
          e_flags:ef, e_cnt:ec};
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, step, act, exp);
    end
  endtask

  task automatic check_out();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard step %0d: got empty queue expected an entry", step);
      return;
    end
    e = sb.pop_front();
    chk("hint", int'(hint_o), int'(e.e_hint));
    chk("tries_left", int'(tries_left), int'(e.e_tries));
    chk("flags", int'({playing, win, lose}), int'(e.e_flags));
`ifdef HINT_COUNT_EN
    chk("match_cnt", int'(match_cnt), int'(e.e_cnt));
`endif
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    rst          = v.rst;
    start        = v.start;
    enter        = v.enter;
    sw_senha     = v.senha;
    sw_tentativa = v.tent;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_out();
    step++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; enter = 1'b0; sw_senha = '0; sw_tentativa = '0;

    // reset with start held, then release: no round may start
    vecs.push_back(mk(1,1,0, 6'b000000, 6'b000000, 6'b000000, 2'd0, 3'b000, 3'd0));
    vecs.push_back(mk(1,1,0, 6'b101100, 6'b000000, 6'b000000, 2'd0, 3'b000, 3'd0));
    vecs.push_back(mk(0,1,0, 6'b101100, 6'b000000, 6'b000000, 2'd0, 3'b000, 3'd0));
    vecs.push_back(mk(0,1,1, 6'b101100, 6'b101100, 6'b000000, 2'd0, 3'b000, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b101100, 6'b000000, 6'b000000, 2'd0, 3'b000, 3'd0));
    // first round, partial hint then win, further enter frozen
    vecs.push_back(mk(0,1,0, 6'b101100, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b101000, 6'b111011, 2'd2, 3'b100, 3'd5));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b101000, 6'b111011, 2'd2, 3'b100, 3'd5));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b101100, 6'b111111, 2'd1, 3'b010, 3'd6));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b101100, 6'b111111, 2'd1, 3'b010, 3'd6));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b000000, 6'b111111, 2'd1, 3'b010, 3'd6));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b000000, 6'b111111, 2'd1, 3'b010, 3'd6));
    // three wrong guesses -> LOSE, then enter ignored
    vecs.push_back(mk(0,1,0, 6'b000111, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b111000, 6'b000000, 2'd2, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b111000, 6'b000000, 2'd2, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b111000, 6'b000000, 2'd1, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b111000, 6'b000000, 2'd1, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b111000, 6'b000000, 2'd0, 3'b001, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b111000, 6'b000000, 2'd0, 3'b001, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b000111, 6'b000000, 2'd0, 3'b001, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b000111, 6'b000000, 2'd0, 3'b001, 3'd0));
    // same secret, correct guess on the last try wins
    vecs.push_back(mk(0,1,0, 6'b000111, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b111000, 6'b000000, 2'd2, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b111000, 6'b000000, 2'd2, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b111000, 6'b000000, 2'd1, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b111000, 6'b000000, 2'd1, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b000111, 6'b111111, 2'd0, 3'b010, 3'd6));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b000111, 6'b111111, 2'd0, 3'b010, 3'd6));
    // simultaneous start and enter: start wins, guess discarded
    vecs.push_back(mk(0,1,0, 6'b010101, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b000000, 6'b101010, 2'd2, 3'b100, 3'd3));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b000000, 6'b101010, 2'd2, 3'b100, 3'd3));
    vecs.push_back(mk(0,1,1, 6'b010101, 6'b010101, 6'b000000, 2'd3, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    vecs.push_back(mk(0,0,1, 6'b000000, 6'b010101, 6'b111111, 2'd2, 3'b010, 3'd6));
    vecs.push_back(mk(0,0,0, 6'b000000, 6'b010101, 6'b111111, 2'd2, 3'b010, 3'd6));
    // new round for the held-enter sequence
    vecs.push_back(mk(0,1,0, 6'b110011, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));

    foreach (vecs[i]) apply(vecs[i]);

    // enter held 10 cycles counts as one guess
    for (int i = 0; i < 10; i++)
      apply(mk(0,0,1, 6'b000000, 6'b000000, 6'b001100, 2'd2, 3'b100, 3'd2));
    apply(mk(0,0,0, 6'b000000, 6'b000000, 6'b001100, 2'd2, 3'b100, 3'd2));

    // reset mid-round aborts to IDLE; enter alone cannot start a round
    apply(mk(1,0,0, 6'b000000, 6'b000000, 6'b000000, 2'd0, 3'b000, 3'd0));
    apply(mk(0,0,1, 6'b000000, 6'b000000, 6'b000000, 2'd0, 3'b000, 3'd0));
    apply(mk(0,1,0, 6'b000000, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    apply(mk(0,0,0, 6'b000000, 6'b000000, 6'b000000, 2'd3, 3'b100, 3'd0));
    apply(mk(0,0,1, 6'b000000, 6'b000000, 6'b111111, 2'd2, 3'b010, 3'd6));

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
